reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
// Producer-side counterpart to the EX-stage operand-forwarding logic. It tracks
// destination registers that are in flight between issue (leaving ID) and
// write-back, and stalls ID when a source operand, or a new destination, is still
// pending. Sits beside the ID/EX register; its Stall output gates the PC and IF/ID
// write enables and inserts a bubble into ID/EX.
// PARAMETERS
// NREG     32  number of architectural registers (register 0 is never tracked)
// CNT_W    3   width of each per-register in-flight counter
// MAX_CNT  7   saturation limit per register (must be <= 2**CNT_W-1)
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      synchronous, active-high reset
// Issue      in   1      instruction in ID requests to advance into EX this cycle
// RegWr_ID   in   1      issuing instruction writes a register
// AddrC_ID   in   5      destination register of the issuing instruction
// Rs_ID      in   5      source register A of the instruction in ID
// Rt_ID      in   5      source register B of the instruction in ID
// UseRs_ID   in   1      instruction in ID actually reads Rs
// UseRt_ID   in   1      instruction in ID actually reads Rt
// RegWr_WB   in   1      write-back stage writes a register this cycle
// AddrC_WB   in   5      write-back destination register
// Squash     in   1      an issued, not-yet-retired writer is killed this cycle
// AddrC_SQ   in   5      destination register of the squashed writer
// Stall      out  1      hold ID and inject a bubble (combinational from state + inputs)
// Busy       out  1      registered; 1 when any counter is non-zero
// Underflow  out  1      registered, sticky; retire/squash hit a zero counter
// BEHAVIOUR
// - State: cnt[r], CNT_W bits, for r = 1..NREG-1; cnt[0] is constant 0.
// - Reset (synchronous): on a clk edge with reset=1, all cnt <= 0, Busy <= 0,
//   Underflow <= 0. reset overrides every other input in that cycle.
// - Addresses equal to 0 are ignored for every source and destination check and
//   for every counter update.
// - ret_r  = RegWr_WB & (AddrC_WB == r). This is a same-cycle bypass: the
//   register file writes before it reads.
// - hazA   = UseRs_ID & Rs_ID != 0 & (cnt[Rs_ID] - ret_Rs_ID) != 0.
//   hazB is the same test for Rt.
// - fullC  = RegWr_ID & AddrC_ID != 0 & cnt[AddrC_ID] == MAX_CNT & !ret_AddrC_ID.
// - Stall  = Issue & (hazA | hazB | fullC). Stall is 0 whenever Issue = 0.
// - iss    = Issue & !Stall & RegWr_ID & AddrC_ID != 0.
// - Per-register next state, evaluated independently. Each of inc (iss), dec1 (WB)
//   and dec2 (Squash) targets at most one register.
//     cnt[r] <= cnt[r] + inc_r - dec1_r - dec2_r
//   Issue, retire and squash of the same r in one cycle net to -1.
//   Issue plus retire of the same r in one cycle leaves cnt unchanged.
// - Underflow guard: if the decrements for r exceed cnt[r] + inc_r, clamp cnt[r]
//   to 0 and set Underflow <= 1. Underflow stays 1 until reset.
// - Busy <= OR of all next-state cnt values (1 cycle after the update).
// - Latency: a count change is visible to Stall on the cycle after the update
//   edge. A retire is visible to Stall in the same cycle via ret_r.
// - No overflow: fullC guarantees cnt never exceeds MAX_CNT.
// - A reset asserted mid-operation discards all pending state. The pipeline
//   flushes alongside it.
// TESTING
// 1. reset=1 for 1 cycle; Issue=1 RegWr_ID=1 AddrC_ID=5 -> Stall=0; next cycle
//    cnt[5]=1, Busy=1.
// 2. cnt[5]=1; ID reads Rs=5 UseRs=1 Issue=1 -> Stall=1. Same cycle with
//    RegWr_WB=1 AddrC_WB=5 -> Stall=0.
// 3. cnt[5]=1; retire r5 and issue a writer to r5 in the same cycle -> cnt[5]
//    stays 1, Busy stays 1.
// 4. Issue 7 writers to r9 with no retire -> cnt[9]=7. The 8th issue -> Stall=1
//    and cnt[9] stays 7. Retire one in the same cycle -> the 8th issues and
//    cnt[9] stays 7.
// 5. AddrC_ID=0, Rs_ID=0 with UseRs=1, Issue=1 -> Stall=0, all cnt unchanged,
//    Busy=0.
// 6. cnt[3]=0; RegWr_WB=1 AddrC_WB=3 -> cnt[3]=0, Underflow=1 and it stays 1;
//    then reset=1 -> Underflow=0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight destination registers between issue and
// write-back and stalls ID on pending sources or a saturated destination.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Issue               instruction in ID requests to advance into EX
//   RegWr_ID, AddrC_ID  issuing instruction writes AddrC_ID
//   Rs_ID, Rt_ID        source registers of the instruction in ID
//   UseRs_ID, UseRt_ID  instruction actually reads Rs / Rt
//   RegWr_WB, AddrC_WB  write-back retires a writer of AddrC_WB
//   Squash, AddrC_SQ    an issued writer of AddrC_SQ is killed
//   Stall               combinational: hold ID, bubble ID/EX
//   Busy                registered: some register is still in flight
//   Underflow           registered, sticky: retire/squash hit a zero count
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int CNT_W   = 3,
    parameter int MAX_CNT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Issue,
    input  logic       RegWr_ID,
    input  logic [4:0] AddrC_ID,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       UseRs_ID,
    input  logic       UseRt_ID,
    input  logic       RegWr_WB,
    input  logic [4:0] AddrC_WB,
    input  logic       Squash,
    input  logic [4:0] AddrC_SQ,
    output logic       Stall,
    output logic       Busy,
    output logic       Underflow
);

    // Two extra bits hold the signed range -2 .. MAX_CNT+1 of one update.
    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_CNT);

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [SW-1:0]    sum     [NREG];
    logic [NREG-1:0]  uf;
    logic             busy_nxt;

    logic             ret_a;
    logic             ret_b;
    logic             ret_c;
    logic [CNT_W-1:0] left_a;
    logic [CNT_W-1:0] left_b;
    logic             haz_a;
    logic             haz_b;
    logic             full_c;
    logic             iss;

    // Hazard detection. A write-back in this cycle counts as already
    // retired because the register file writes before it reads.
    always_comb begin
        ret_a  = RegWr_WB && (AddrC_WB == Rs_ID);
        ret_b  = RegWr_WB && (AddrC_WB == Rt_ID);
        ret_c  = RegWr_WB && (AddrC_WB == AddrC_ID);
        left_a = cnt[Rs_ID] - CNT_W'(ret_a);
        left_b = cnt[Rt_ID] - CNT_W'(ret_b);
        haz_a  = UseRs_ID && (Rs_ID != '0) && (left_a != '0);
        haz_b  = UseRt_ID && (Rt_ID != '0) && (left_b != '0);
        full_c = RegWr_ID && (AddrC_ID != '0)
                 && (cnt[AddrC_ID] == CMAX) && !ret_c;
        Stall  = Issue && (haz_a || haz_b || full_c);
        iss    = Issue && !Stall && RegWr_ID && (AddrC_ID != '0);
    end

    // Per-register next count; a negative result clamps to zero and flags
    // underflow. Register 0 is never tracked.
    always_comb begin
        busy_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            sum[r] = {2'b00, cnt[r]}
                     + SW'(iss && (AddrC_ID == 5'(r)))
                     - SW'(RegWr_WB && (AddrC_WB == 5'(r)))
                     - SW'(Squash && (AddrC_SQ == 5'(r)));
            uf[r] = (r != 0) && ($signed(sum[r]) < 0);
            if ((r == 0) || ($signed(sum[r]) < 0)) begin
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = sum[r][CNT_W-1:0];
            end
            busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            Busy      <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            Busy      <= busy_nxt;
            Underflow <= Underflow | (|uf);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus randomized traffic checked
// against a counting model of in-flight register writers.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Issue = 1'b0;
    logic       RegWr_ID = 1'b0;
    logic [4:0] AddrC_ID = '0;
    logic [4:0] Rs_ID = '0;
    logic [4:0] Rt_ID = '0;
    logic       UseRs_ID = 1'b0;
    logic       UseRt_ID = 1'b0;
    logic       RegWr_WB = 1'b0;
    logic [4:0] AddrC_WB = '0;
    logic       Squash = 1'b0;
    logic [4:0] AddrC_SQ = '0;
    logic       Stall;
    logic       Busy;
    logic       Underflow;

    int nchecks = 0;
    int nerr = 0;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .Issue(Issue),
        .RegWr_ID(RegWr_ID), .AddrC_ID(AddrC_ID),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
        .RegWr_WB(RegWr_WB), .AddrC_WB(AddrC_WB),
        .Squash(Squash), .AddrC_SQ(AddrC_SQ),
        .Stall(Stall), .Busy(Busy), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       issue;
        logic       rw;
        logic [4:0] c;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wbw;
        logic [4:0] wba;
        logic       sq;
        logic [4:0] sqa;
    } stim_t;

    // Model: number of writers in flight per register, plain integers.
    int mcnt [32];
    bit mbusy;
    bit muf;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] d);
        stim_t s;
        s = '0;
        s.issue = 1'b1;
        s.rw = 1'b1;
        s.c = d;
        return s;
    endfunction

    function automatic bit m_stall(input stim_t s);
        int pa;
        int pb;
        bit ha;
        bit hb;
        bit fc;
        pa = mcnt[s.rs] - ((s.wbw && s.wba == s.rs) ? 1 : 0);
        pb = mcnt[s.rt] - ((s.wbw && s.wba == s.rt) ? 1 : 0);
        ha = s.urs && s.rs != 0 && pa != 0;
        hb = s.urt && s.rt != 0 && pb != 0;
        fc = s.rw && s.c != 0 && mcnt[s.c] == 7
             && !(s.wbw && s.wba == s.c);
        return s.issue && (ha || hb || fc);
    endfunction

    // Drive one cycle, capture Stall before the edge, advance the model.
    task automatic apply(input stim_t s, output logic so, output bit se);
        int d [32];
        int v;
        @(negedge clk);
        reset = s.rst;
        Issue = s.issue;
        RegWr_ID = s.rw;
        AddrC_ID = s.c;
        Rs_ID = s.rs;
        Rt_ID = s.rt;
        UseRs_ID = s.urs;
        UseRt_ID = s.urt;
        RegWr_WB = s.wbw;
        AddrC_WB = s.wba;
        Squash = s.sq;
        AddrC_SQ = s.sqa;
        #1;
        so = Stall;
        se = m_stall(s);
        @(posedge clk);
        if (s.rst) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            mbusy = 0;
            muf = 0;
        end else begin
            for (int r = 0; r < 32; r++) d[r] = 0;
            if (s.issue && !se && s.rw && s.c != 0) d[s.c]++;
            if (s.wbw && s.wba != 0) d[s.wba]--;
            if (s.sq && s.sqa != 0) d[s.sqa]--;
            mbusy = 0;
            for (int r = 1; r < 32; r++) begin
                v = mcnt[r] + d[r];
                if (v < 0) begin
                    v = 0;
                    muf = 1;
                end
                mcnt[r] = v;
                if (v != 0) mbusy = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        logic so;
        bit se;
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s, so, se);
    endtask

    task automatic test_reset();
        logic so;
        bit se;
        stim_t s;
        s = wr(5'd6);
        apply(s, so, se);
        s.wbw = 1'b1;
        s.wba = 5'd7;
        apply(s, so, se);
        do_reset();
        nchecks++;
        if (Busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy got=%b want=0", Busy);
        end
        nchecks++;
        if (Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL reset_uf got=%b want=0", Underflow);
        end
    endtask

    task automatic test_issue();
        logic so;
        bit se;
        do_reset();
        apply(wr(5'd5), so, se);
        nchecks++;
        if (so !== 1'b0) begin
            nerr++;
            $display("FAIL issue_stall got=%b want=0", so);
        end
        nchecks++;
        if (Busy !== 1'b1) begin
            nerr++;
            $display("FAIL issue_busy got=%b want=1", Busy);
        end
    endtask

    task automatic test_bypass();
        logic so;
        bit se;
        stim_t s;
        bit want [4];
        do_reset();
        apply(wr(5'd5), so, se);
        want = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            s = idle();
            s.issue = (k != 3);
            s.rs = 5'd5;
            s.rt = 5'd5;
            s.urs = (k == 0 || k == 3);
            s.urt = (k == 1 || k == 3);
            apply(s, so, se);
            nchecks++;
            if (so !== want[k]) begin
                nerr++;
                $display("FAIL src_haz%0d got=%b want=%b", k, so, want[k]);
            end
        end
        s = idle();
        s.issue = 1'b1;
        s.rs = 5'd5;
        s.urs = 1'b1;
        s.wbw = 1'b1;
        s.wba = 5'd5;
        apply(s, so, se);
        nchecks++;
        if (so !== 1'b0) begin
            nerr++;
            $display("FAIL wb_bypass got=%b want=0", so);
        end
        nchecks++;
        if (Busy !== 1'b0) begin
            nerr++;
            $display("FAIL bypass_busy got=%b want=0", Busy);
        end
    endtask

    task automatic test_issue_retire();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        apply(wr(5'd5), so, se);
        s = wr(5'd5);
        s.wbw = 1'b1;
        s.wba = 5'd5;
        apply(s, so, se);
        nchecks++;
        if (so !== 1'b0 || Busy !== 1'b1) begin
            nerr++;
            $display("FAIL iss_ret stall=%b busy=%b want 0/1", so, Busy);
        end
        s = idle();
        s.wbw = 1'b1;
        s.wba = 5'd5;
        apply(s, so, se);
        nchecks++;
        if (Busy !== 1'b0 || Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL iss_ret_drain busy=%b uf=%b want 0/0",
                     Busy, Underflow);
        end
    endtask

    task automatic test_squash();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        apply(wr(5'd4), so, se);
        apply(wr(5'd4), so, se);
        s = wr(5'd4);
        s.wbw = 1'b1;
        s.wba = 5'd4;
        s.sq = 1'b1;
        s.sqa = 5'd4;
        apply(s, so, se);
        nchecks++;
        if (Busy !== 1'b1) begin
            nerr++;
            $display("FAIL squash_net got=%b want=1", Busy);
        end
        s = idle();
        s.sq = 1'b1;
        s.sqa = 5'd4;
        apply(s, so, se);
        nchecks++;
        if (Busy !== 1'b0 || Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL squash_last busy=%b uf=%b want 0/0",
                     Busy, Underflow);
        end
    endtask

    task automatic test_saturate();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(wr(5'd9), so, se);
            nchecks++;
            if (so !== 1'b0) begin
                nerr++;
                $display("FAIL sat_fill%0d got=%b want=0", i, so);
            end
        end
        apply(wr(5'd9), so, se);
        nchecks++;
        if (so !== 1'b1) begin
            nerr++;
            $display("FAIL sat_full got=%b want=1", so);
        end
        s = wr(5'd9);
        s.wbw = 1'b1;
        s.wba = 5'd9;
        apply(s, so, se);
        nchecks++;
        if (so !== 1'b0) begin
            nerr++;
            $display("FAIL sat_ret got=%b want=0", so);
        end
        s = idle();
        s.wbw = 1'b1;
        s.wba = 5'd9;
        for (int k = 0; k < 7; k++) begin
            apply(s, so, se);
            nchecks++;
            if (Busy !== (k < 6)) begin
                nerr++;
                $display("FAIL sat_drain%0d got=%b want=%b",
                         k, Busy, (k < 6));
            end
        end
        nchecks++;
        if (Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL sat_uf got=%b want=0", Underflow);
        end
    endtask

    task automatic test_zero();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        s = wr(5'd0);
        s.urs = 1'b1;
        s.urt = 1'b1;
        apply(s, so, se);
        nchecks++;
        if (so !== 1'b0 || Busy !== 1'b0) begin
            nerr++;
            $display("FAIL zero_reg stall=%b busy=%b want 0/0", so, Busy);
        end
        s = idle();
        s.wbw = 1'b1;
        s.sq = 1'b1;
        apply(s, so, se);
        nchecks++;
        if (Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL zero_uf got=%b want=0", Underflow);
        end
    endtask

    task automatic test_underflow();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        s = idle();
        s.wbw = 1'b1;
        s.wba = 5'd3;
        apply(s, so, se);
        nchecks++;
        if (Underflow !== 1'b1 || Busy !== 1'b0) begin
            nerr++;
            $display("FAIL uf_set uf=%b busy=%b want 1/0", Underflow, Busy);
        end
        apply(idle(), so, se);
        nchecks++;
        if (Underflow !== 1'b1) begin
            nerr++;
            $display("FAIL uf_sticky got=%b want=1", Underflow);
        end
        do_reset();
        nchecks++;
        if (Underflow !== 1'b0) begin
            nerr++;
            $display("FAIL uf_clear got=%b want=0", Underflow);
        end
    endtask

    task automatic test_random();
        logic so;
        bit se;
        stim_t s;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst = ($urandom_range(0, 59) == 0);
            s.issue = ($urandom_range(0, 9) < 8);
            s.rw = ($urandom_range(0, 9) < 8);
            s.c = 5'($urandom_range(0, 3));
            s.rs = 5'($urandom_range(0, 3));
            s.rt = 5'($urandom_range(0, 3));
            s.urs = ($urandom_range(0, 9) < 3);
            s.urt = ($urandom_range(0, 9) < 2);
            s.wbw = ($urandom_range(0, 9) < 4);
            s.wba = 5'($urandom_range(0, 3));
            s.sq = ($urandom_range(0, 9) == 0);
            s.sqa = 5'($urandom_range(0, 3));
            apply(s, so, se);
            nchecks++;
            if (so !== se) begin
                nerr++;
                $display("FAIL rnd_stall cyc=%0d got=%b want=%b",
                         i, so, se);
            end
            nchecks++;
            if (Busy !== mbusy) begin
                nerr++;
                $display("FAIL rnd_busy cyc=%0d got=%b want=%b",
                         i, Busy, mbusy);
            end
            nchecks++;
            if (Underflow !== muf) begin
                nerr++;
                $display("FAIL rnd_uf cyc=%0d got=%b want=%b",
                         i, Underflow, muf);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mbusy = 0;
        muf = 0;
        test_reset();
        test_issue();
        test_bypass();
        test_issue_retire();
        test_squash();
        test_saturate();
        test_zero();
        test_underflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
